// File: rtl/enc64_pkg.sv
// rtl/enc64_pkg.sv - shared widths, vector/index types and one-hot helper for the 64->6 encoder
package enc64_pkg;

  localparam int ENC_N     = 64;
  localparam int ENC_IDX_W = 6;

  typedef logic [ENC_N-1:0]     enc_vec_t;
  typedef logic [ENC_IDX_W-1:0] enc_idx_t;

  function automatic enc_vec_t idx2onehot(input enc_idx_t idx);
    idx2onehot = enc_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/ffs_64.sv
// rtl/ffs_64.sv - combinational find-first-set over 64 bits, lowest index wins
module ffs_64
  import enc64_pkg::*;
(
  input  enc_vec_t vec_i,
  output logic     any_o,
  output enc_idx_t idx_o
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    any_o = |vec_i;
    idx_o = '0;
    for (int i = ENC_N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = enc_idx_t'(i);
    end
  end

endmodule

// File: rtl/rr_encoder_64_6.sv
// rtl/rr_encoder_64_6.sv - round-robin 64->6 encoder with registered valid/ready output
// Optional out_onehot port under RR_ENC64_ONEHOT_OUT_EN.
module rr_encoder_64_6
  import enc64_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  enc_vec_t req_i,
  input  logic     flush_i,
  output logic     out_valid,
  input  logic     out_ready,
  output enc_idx_t out_idx,
  output enc_idx_t ptr_o
`ifdef RR_ENC64_ONEHOT_OUT_EN
  ,
  output enc_vec_t out_onehot
`endif
);

  logic     r_valid;
  enc_idx_t r_idx;
  enc_idx_t r_ptr;

  enc_vec_t w_hold_mask;
  enc_vec_t w_req_eff;
  enc_vec_t w_upper;
  logic     w_upper_any;
  enc_idx_t w_upper_idx;
  logic     w_full_any;
  enc_idx_t w_full_idx;
  enc_idx_t w_sel;
  logic     w_load;

  // The held index is masked so a stalled or firing entry is never picked twice.
  assign w_hold_mask = r_valid ? idx2onehot(r_idx) : '0;
  assign w_req_eff   = req_i & ~w_hold_mask;
  assign w_upper     = w_req_eff & (enc_vec_t'({ENC_N{1'b1}}) << r_ptr);

  ffs_64 u_ffs_upper (
    .vec_i (w_upper),
    .any_o (w_upper_any),
    .idx_o (w_upper_idx)
  );

  ffs_64 u_ffs_full (
    .vec_i (w_req_eff),
    .any_o (w_full_any),
    .idx_o (w_full_idx)
  );

  assign w_sel  = w_upper_any ? w_upper_idx : w_full_idx;
  assign w_load = ~r_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      if (w_full_any) begin
        r_valid <= 1'b1;
        r_idx   <= w_sel;
        r_ptr   <= w_sel + enc_idx_t'(1);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef RR_ENC64_ONEHOT_OUT_EN
  enc_vec_t r_onehot;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_onehot <= '0;
    end else if (w_load) begin
      r_onehot <= w_full_any ? idx2onehot(w_sel) : '0;
    end
  end

  assign out_onehot = r_onehot;
`endif

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign ptr_o     = r_ptr;

endmodule
